// File: rtl/entry_buffer_if.sv
// Shared enums and the dispatch / issue / completion / retire bundle of the entry buffer.
// The buffer connects through the slave modport; the surrounding pipeline uses master.
package entry_buffer_pkg;
  typedef enum logic [2:0] {U_ALU, U_MUL, U_DIV, U_LOAD, U_STORE, U_BRANCH} unit_e;
  typedef enum logic [1:0] {S_NOT_EXECUTED, S_EXECUTING, S_EXECUTED} estate_e;
endpackage

interface entry_buffer_if #(
  parameter int BUF_SIZE     = 8,
  parameter int BUF_SIZE_LOG = 3
);
  import entry_buffer_pkg::*;

  logic [1:0]                     in_valid;
  unit_e                          in_unit [2];
  logic [1:0][4:0]                in_rs1;
  logic [1:0][4:0]                in_rs2;
  logic [1:0][4:0]                in_rd;
  logic                           in_ready;

  logic [BUF_SIZE_LOG:0]          entries_tag   [BUF_SIZE];
  estate_e                        entries_state [BUF_SIZE];
  logic [BUF_SIZE_LOG:0]          entries_qj    [BUF_SIZE];
  logic [BUF_SIZE_LOG:0]          entries_qk    [BUF_SIZE];
  unit_e                          entries_unit  [BUF_SIZE];
  logic [4:0]                     entries_rd    [BUF_SIZE];

  logic [1:0]                     grant_valid;
  logic [1:0][BUF_SIZE_LOG-1:0]   grant_idx;

  logic                           cdb_valid;
  logic [BUF_SIZE_LOG-1:0]        cdb_idx;

  logic                           retire_valid;
  logic [BUF_SIZE_LOG-1:0]        retire_idx;
  logic [4:0]                     retire_rd;

  modport master (
    output in_valid, in_unit, in_rs1, in_rs2, in_rd,
    output grant_valid, grant_idx, cdb_valid, cdb_idx,
    input  in_ready,
    input  entries_tag, entries_state, entries_qj, entries_qk, entries_unit, entries_rd,
    input  retire_valid, retire_idx, retire_rd
  );

  modport slave (
    input  in_valid, in_unit, in_rs1, in_rs2, in_rd,
    input  grant_valid, grant_idx, cdb_valid, cdb_idx,
    output in_ready,
    output entries_tag, entries_state, entries_qj, entries_qk, entries_unit, entries_rd,
    output retire_valid, retire_idx, retire_rd
  );
endinterface

// File: rtl/entry_buffer.sv
// Two-wide dispatch entry buffer with age tags, register renaming status table,
// CDB wakeup and strictly in-order single retirement of the oldest entry.
module entry_buffer
  import entry_buffer_pkg::*;
#(
  parameter int BUF_SIZE     = 8,
  parameter int BUF_SIZE_LOG = 3
) (
  input logic           clk,
  input logic           reset,
  entry_buffer_if.slave bus
);
  localparam int TW = BUF_SIZE_LOG + 1;
  localparam int IW = BUF_SIZE_LOG;
  localparam logic [TW-1:0] ONE    = TW'(1);
  localparam logic [TW-1:0] SIZE_T = TW'(BUF_SIZE);

  logic [TW-1:0] r_tag    [BUF_SIZE];
  estate_e       r_state  [BUF_SIZE];
  logic [TW-1:0] r_qj     [BUF_SIZE];
  logic [TW-1:0] r_qk     [BUF_SIZE];
  unit_e         r_unit   [BUF_SIZE];
  logic [4:0]    r_rd     [BUF_SIZE];
  logic [TW-1:0] r_status [32];
  logic          r_ret_valid;
  logic [IW-1:0] r_ret_idx;
  logic [4:0]    r_ret_rd;

  logic [TW-1:0] w_tag_n    [BUF_SIZE];
  estate_e       w_state_n  [BUF_SIZE];
  logic [TW-1:0] w_qj_n     [BUF_SIZE];
  logic [TW-1:0] w_qk_n     [BUF_SIZE];
  unit_e         w_unit_n   [BUF_SIZE];
  logic [4:0]    w_rd_n     [BUF_SIZE];
  logic [TW-1:0] w_status_n [32];

  logic [TW-1:0] w_count;
  logic [TW-1:0] w_free;
  logic          w_in_ready;
  logic [IW-1:0] w_free0;
  logic [IW-1:0] w_free1;
  logic [1:0]    w_found;
  logic          w_retire;
  logic [IW-1:0] w_ret_idx;
  logic [1:0]    w_acc;
  logic [TW-1:0] w_n;
  logic [IW-1:0] w_slot_idx [2];
  logic [TW-1:0] w_slot_tag [2];
  logic [TW-1:0] w_src_qj   [2];
  logic [TW-1:0] w_src_qk   [2];
  logic [4:0]    w_rs;
  logic [TW-1:0] w_prod;
  logic [TW-1:0] w_cdb_tag;

  // Occupancy, the two lowest free slots and the oldest-entry retire candidate,
  // all derived from registered state so a freed index is reused only next cycle.
  always_comb begin
    w_count   = '0;
    w_free0   = '0;
    w_free1   = '0;
    w_found   = 2'd0;
    w_retire  = 1'b0;
    w_ret_idx = '0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (r_tag[i] != '0) begin
        w_count = w_count + ONE;
      end else if (w_found == 2'd0) begin
        w_free0 = IW'(i);
        w_found = 2'd1;
      end else if (w_found == 2'd1) begin
        w_free1 = IW'(i);
        w_found = 2'd2;
      end
    end
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (r_tag[i] != '0 && r_tag[i] == w_count && r_state[i] == S_EXECUTED) begin
        w_retire  = 1'b1;
        w_ret_idx = IW'(i);
      end
    end
    w_free     = SIZE_T - w_count;
    w_in_ready = (w_free >= TW'(2));
  end

  // Dispatch placement and source operand renaming for both slots.
  always_comb begin
    w_acc         = w_in_ready ? bus.in_valid : 2'b00;
    w_n           = TW'(w_acc[0]) + TW'(w_acc[1]);
    w_cdb_tag     = {1'b0, bus.cdb_idx} + ONE;
    w_slot_idx[0] = w_free0;
    w_slot_idx[1] = w_acc[0] ? w_free1 : w_free0;
    w_slot_tag[0] = w_n;
    w_slot_tag[1] = ONE;
    w_rs          = '0;
    w_prod        = '0;
    for (int s = 0; s < 2; s++) begin
      w_src_qj[s] = '0;
      w_src_qk[s] = '0;
      for (int k = 0; k < 2; k++) begin
        w_rs   = (k == 0) ? bus.in_rs1[s] : bus.in_rs2[s];
        w_prod = (w_rs == 5'd0) ? '0 : r_status[w_rs];
        // A producer that already completed (or completes right now) is no dependency.
        if (w_prod != '0) begin
          if (r_state[IW'(w_prod - ONE)] == S_EXECUTED ||
              (bus.cdb_valid && w_prod == w_cdb_tag)) begin
            w_prod = '0;
          end
        end
        if (s == 1 && w_acc[0] && bus.in_rd[0] != 5'd0 && w_rs == bus.in_rd[0]) begin
          w_prod = {1'b0, w_slot_idx[0]} + ONE;
        end
        if (k == 0) begin
          w_src_qj[s] = w_prod;
        end else begin
          w_src_qk[s] = w_prod;
        end
      end
    end
  end

  // Next state of every entry and of the status table. Later writes win:
  // grant, then CDB, then retire, then allocation of new entries.
  always_comb begin
    w_tag_n    = r_tag;
    w_state_n  = r_state;
    w_qj_n     = r_qj;
    w_qk_n     = r_qk;
    w_unit_n   = r_unit;
    w_rd_n     = r_rd;
    w_status_n = r_status;

    for (int i = 0; i < BUF_SIZE; i++) begin
      if (r_tag[i] != '0) begin
        w_tag_n[i] = r_tag[i] + w_n;
      end
    end

    for (int g = 0; g < 2; g++) begin
      if (bus.grant_valid[g] && r_tag[bus.grant_idx[g]] != '0 &&
          r_state[bus.grant_idx[g]] == S_NOT_EXECUTED) begin
        w_state_n[bus.grant_idx[g]] = S_EXECUTING;
      end
    end

    if (bus.cdb_valid) begin
      w_state_n[bus.cdb_idx] = S_EXECUTED;
      for (int i = 0; i < BUF_SIZE; i++) begin
        if (r_qj[i] == w_cdb_tag) w_qj_n[i] = '0;
        if (r_qk[i] == w_cdb_tag) w_qk_n[i] = '0;
      end
    end

    if (w_retire) begin
      w_tag_n[w_ret_idx] = '0;
      if (r_status[r_rd[w_ret_idx]] == {1'b0, w_ret_idx} + ONE) begin
        w_status_n[r_rd[w_ret_idx]] = '0;
      end
    end

    for (int s = 0; s < 2; s++) begin
      if (w_acc[s]) begin
        w_tag_n[w_slot_idx[s]]   = w_slot_tag[s];
        w_state_n[w_slot_idx[s]] = S_NOT_EXECUTED;
        w_qj_n[w_slot_idx[s]]    = w_src_qj[s];
        w_qk_n[w_slot_idx[s]]    = w_src_qk[s];
        w_unit_n[w_slot_idx[s]]  = bus.in_unit[s];
        w_rd_n[w_slot_idx[s]]    = bus.in_rd[s];
        if (bus.in_rd[s] != 5'd0) begin
          w_status_n[bus.in_rd[s]] = {1'b0, w_slot_idx[s]} + ONE;
        end
      end
    end
    w_status_n[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BUF_SIZE; i++) begin
        r_tag[i]   <= '0;
        r_state[i] <= S_NOT_EXECUTED;
        r_qj[i]    <= '0;
        r_qk[i]    <= '0;
        r_unit[i]  <= U_ALU;
        r_rd[i]    <= '0;
      end
      for (int r = 0; r < 32; r++) begin
        r_status[r] <= '0;
      end
      r_ret_valid <= 1'b0;
      r_ret_idx   <= '0;
      r_ret_rd    <= '0;
    end else begin
      r_tag       <= w_tag_n;
      r_state     <= w_state_n;
      r_qj        <= w_qj_n;
      r_qk        <= w_qk_n;
      r_unit      <= w_unit_n;
      r_rd        <= w_rd_n;
      r_status    <= w_status_n;
      r_ret_valid <= w_retire;
      r_ret_idx   <= w_ret_idx;
      r_ret_rd    <= r_rd[w_ret_idx];
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.entries_tag   = r_tag;
  assign bus.entries_state = r_state;
  assign bus.entries_qj    = r_qj;
  assign bus.entries_qk    = r_qk;
  assign bus.entries_unit  = r_unit;
  assign bus.entries_rd    = r_rd;
  assign bus.retire_valid  = r_ret_valid;
  assign bus.retire_idx    = r_ret_idx;
  assign bus.retire_rd     = r_ret_rd;
endmodule

// File: doc/entry_buffer.md
ENTRY_BUFFER -- requirements
Module: entry_buffer

Interface
REQ-001 Parameter BUF_SIZE, default 8, number of buffer entries.
REQ-002 Parameter BUF_SIZE_LOG, default 3, index width, log2(BUF_SIZE).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  2  per-slot dispatch request; slot 0 is program-older than slot 1.
REQ-006 in_unit  input  2 x unit-enum  functional unit of each slot (STORE among values).
REQ-007 in_rs1, in_rs2, in_rd  input  2 x 5  source and destination register numbers per slot.
REQ-008 in_ready  output  1  high when at least 2 entries are free.
REQ-009 entries  output  BUF_SIZE x entry  tag, e_state, Qj, Qk, Unit, rd of every entry, driven directly from registers to the issue stage.
REQ-010 grant_valid, grant_idx  input  2 x 1, 2 x BUF_SIZE_LOG  entries selected by the issue stage this cycle.
REQ-011 cdb_valid, cdb_idx  input  1, BUF_SIZE_LOG  completion broadcast of entry cdb_idx.
REQ-012 retire_valid, retire_idx, retire_rd  output  1, BUF_SIZE_LOG, 5  registered retire report.

Function
REQ-013 Tag 0 SHALL mark an empty entry; valid entries SHALL hold distinct tags 1..count, larger = older; tag width BUF_SIZE_LOG+1.
REQ-014 Qj/Qk SHALL hold producer entry index+1, 0 meaning operand ready.
REQ-015 Dispatch SHALL occur only when in_ready is high; requests while in_ready is low SHALL be ignored (no partial accept).
REQ-016 Accepted slots SHALL take the lowest-numbered free indices, slot 0 the lower one.
REQ-017 With n accepted slots (0..2), every surviving valid tag SHALL increase by n; slot 0 gets tag n, slot 1 gets tag 1.
REQ-018 New entries SHALL start in S_NOT_EXECUTED with Unit=in_unit and rd=in_rd.
REQ-019 A 32-entry register status table SHALL map each register to its latest in-flight producer (index+1) or 0; x0 SHALL always read 0 and never be written.
REQ-020 New Qj/Qk SHALL be read from the status table; slot 1 SHALL bypass slot 0's rd when rs matches rd (nonzero).
REQ-021 A source whose producer matches cdb_idx in the same cycle SHALL be written as 0.
REQ-022 Status table SHALL be updated with each accepted rd; slot 1 wins on equal rd.
REQ-023 grant for a valid S_NOT_EXECUTED entry SHALL move it to S_EXECUTING next cycle; grants to other states SHALL be ignored.
REQ-024 cdb_valid SHALL move entry cdb_idx to S_EXECUTED and clear every Qj/Qk equal to cdb_idx+1.
REQ-025 Each cycle, if the entry with tag == count is S_EXECUTED, it SHALL retire: tag set 0, retire_valid/idx/rd registered next cycle; at most one retire per cycle.
REQ-026 On retire, the status table entry for rd SHALL be cleared only if it still holds idx+1; a same-cycle dispatch write to that rd takes priority.
REQ-027 Retire and dispatch in the same cycle SHALL both take effect; a freed index SHALL be reusable only from the next cycle; in_ready SHALL be computed from current-cycle free count.
REQ-028 cdb for the entry retiring the same cycle SHALL not occur (already S_EXECUTED); grant and cdb to the same index in one cycle SHALL yield S_EXECUTED.

Reset
REQ-029 On reset all tags, Qj, Qk SHALL be 0, e_state S_NOT_EXECUTED, status table 0, retire_valid 0, in_ready 1 in the following cycle; reset overrides all same-cycle inputs, including mid-operation.

Verification
REQ-030 After reset, dispatch slot0 rd=x5, slot1 rs1=x5 -> entry0 tag2 Qj0, entry1 tag1 Qj=1.
REQ-031 Fill BUF_SIZE-1 entries -> in_ready 0; further in_valid=2'b11 ignored, tags unchanged.
REQ-032 Same-cycle cdb_idx=0 and dispatch with rs2=x5 (producer 1) -> new Qk=0.
REQ-033 Entry1 executed before entry0 -> no retire until entry0 S_EXECUTED, then retire idx0 then idx1 on consecutive cycles.
REQ-034 Retire idx0 (rd=x5) while dispatching rd=x5 -> status[x5] holds new producer, not 0.
REQ-035 Reset asserted with 6 valid entries and pending cdb -> all tags 0, retire_valid 0 next cycle.
